// File: rtl/regfile_bypass_sb.sv
// ---------------------------------------------------------------------------
// regfile_bypass_sb
//   Integer register file with a busy scoreboard. It sits between decode
//   (reads, issue) and writeback (write).
//   - Two combinational read ports and one synchronous write port.
//   - Register 0 can be hardwired to zero (ZERO_REG).
//   - A same-cycle writeback can be forwarded to the read ports (BYPASS), so
//     the writeback/decode hazard needs no extra cycle.
//   - One busy bit per register marks an outstanding producer. Issue sets
//     the bit, writeback clears it, and flush clears every bit.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   rs1_addr/rs2_addr   read addresses                     (AW)
//   rs1_data/rs2_data   read data, combinational           (XLEN)
//   rs1_busy/rs2_busy   addressed register has a pending producer
//   wr_en/wr_addr/wr_data  writeback port
//   iss_en/iss_rd       decode issued an instruction writing iss_rd
//   flush               clear the whole scoreboard
// ---------------------------------------------------------------------------
module regfile_bypass_sb #(
  parameter int  XLEN     = 32,
  parameter int  NREG     = 32,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic            wr_take;

  // A write to x0 is dropped when x0 is hardwired to zero.
  assign wr_take = wr_en && !(ZERO_REG && (wr_addr == '0));

  // NOTE: the register array is reset because a clean file after reset is
  // part of the block's contract. A storage array that nobody reads before
  // it is written would normally be left without a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_take) regs_q[wr_addr] <= wr_data;
      busy_q <= busy_nxt;
    end
  end

  // NOTE: blocking assignments in combinational logic run in order. The issue
  // set comes after the writeback clear, so set wins on the same register.
  always_comb begin
    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)  busy_nxt[wr_addr] = 1'b0;
      if (iss_en) busy_nxt[iss_rd]  = 1'b1;
    end
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  // Read priority: hardwired zero, then the forwarded write, then storage.
  function automatic logic [XLEN-1:0] read_val(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = regs_q[a];
    if (BYPASS && wr_take && (wr_addr == a)) v = wr_data;
    if (ZERO_REG && (a == '0))               v = '0;
    return v;
  endfunction

  // Busy is masked while the value is being forwarded in this cycle.
  function automatic logic busy_val(input logic [AW-1:0] a);
    return busy_q[a] && !(BYPASS && wr_take && (wr_addr == a));
  endfunction

  // Outputs are forced to 0 while reset is held, including between edges.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rst) begin
      rs1_data = read_val(rs1_addr);
      rs2_data = read_val(rs2_addr);
      rs1_busy = busy_val(rs1_addr);
      rs2_busy = busy_val(rs2_addr);
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass_sb
//   Drives two instances of the register file. Instance A uses the defaults
//   (XLEN=32, NREG=32, BYPASS=1, ZERO_REG=1). Instance B uses XLEN=64,
//   NREG=16, BYPASS=0, ZERO_REG=0.
//   The stimulus process applies directed and random cycles and pushes the
//   expected read/busy values into a queue. A separate monitor pops and
//   compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_bypass_sb;

  typedef struct {
    bit          wr_en;
    int          wr_addr;
    logic [63:0] wr_data;
    bit          iss_en;
    int          iss_rd;
    bit          flush;
    int          rs1;
    int          rs2;
  } stim_t;

  typedef struct {
    string       tag;
    logic [63:0] a_d1, a_d2, b_d1, b_d2;
    bit          a_b1, a_b2, b_b1, b_b2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals.
  logic [4:0]  a_rs1_addr, a_rs2_addr, a_wr_addr, a_iss_rd;
  logic [31:0] a_rs1_data, a_rs2_data, a_wr_data;
  logic        a_rs1_busy, a_rs2_busy, a_wr_en, a_iss_en, a_flush;

  // Instance B signals.
  logic [3:0]  b_rs1_addr, b_rs2_addr, b_wr_addr, b_iss_rd;
  logic [63:0] b_rs1_data, b_rs2_data, b_wr_data;
  logic        b_rs1_busy, b_rs2_busy, b_wr_en, b_iss_en, b_flush;

  regfile_bypass_sb dut_a (
    .clk(clk), .rst(rst),
    .rs1_addr(a_rs1_addr), .rs2_addr(a_rs2_addr),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
    .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_rd(a_iss_rd), .flush(a_flush)
  );

  regfile_bypass_sb #(.XLEN(64), .NREG(16), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_rd(b_iss_rd), .flush(b_flush)
  );

  // ---------------- reference model ----------------
  int          m_n    [2] = '{32, 16};
  bit          m_byp  [2] = '{1'b1, 1'b0};
  bit          m_zero [2] = '{1'b1, 1'b0};
  logic [63:0] m_mask [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] mreg   [2][32];
  bit          mbusy  [2][32];

  task automatic m_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mreg[k][i]  = '0;
        mbusy[k][i] = 1'b0;
      end
  endtask

  function automatic logic [63:0] m_rd(int k, int a, stim_t s);
    if (!rst) return '0;
    if (m_zero[k] && a == 0) return '0;
    if (m_byp[k] && s.wr_en && s.wr_addr == a) return s.wr_data & m_mask[k];
    return mreg[k][a];
  endfunction

  function automatic bit m_bz(int k, int a, stim_t s);
    if (!rst) return 1'b0;
    if (m_zero[k] && a == 0) return 1'b0;
    if (m_byp[k] && s.wr_en && s.wr_addr == a) return 1'b0;
    return mbusy[k][a];
  endfunction

  task automatic m_edge(int k, stim_t s);
    if (s.wr_en && !(m_zero[k] && s.wr_addr == 0))
      mreg[k][s.wr_addr] = s.wr_data & m_mask[k];
    if (s.flush) begin
      for (int i = 0; i < 32; i++) mbusy[k][i] = 1'b0;
    end else begin
      if (s.wr_en) mbusy[k][s.wr_addr] = 1'b0;
      if (s.iss_en && !(m_zero[k] && s.iss_rd == 0)) mbusy[k][s.iss_rd] = 1'b1;
    end
  endtask

  // ---------------- scoreboard / checking ----------------
  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " a.rs1_data"}, {32'h0, a_rs1_data}, e.a_d1);
        check({e.tag, " a.rs2_data"}, {32'h0, a_rs2_data}, e.a_d2);
        check({e.tag, " a.rs1_busy"}, 64'(a_rs1_busy), 64'(e.a_b1));
        check({e.tag, " a.rs2_busy"}, 64'(a_rs2_busy), 64'(e.a_b2));
        check({e.tag, " b.rs1_data"}, b_rs1_data, e.b_d1);
        check({e.tag, " b.rs2_data"}, b_rs2_data, e.b_d2);
        check({e.tag, " b.rs1_busy"}, 64'(b_rs1_busy), 64'(e.b_b1));
        check({e.tag, " b.rs2_busy"}, 64'(b_rs2_busy), 64'(e.b_b2));
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic stim_t idle(int r1, int r2);
    stim_t s;
    s = '{default: '0};
    s.rs1 = r1;
    s.rs2 = r2;
    return s;
  endfunction

  function automatic stim_t wr(int a, logic [63:0] d, int r1, int r2);
    stim_t s;
    s = idle(r1, r2);
    s.wr_en   = 1'b1;
    s.wr_addr = a;
    s.wr_data = d;
    return s;
  endfunction

  function automatic stim_t iss(int rd, int r1, int r2);
    stim_t s;
    s = idle(r1, r2);
    s.iss_en = 1'b1;
    s.iss_rd = rd;
    return s;
  endfunction

  function automatic int ra(int n);
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, n - 1));
  endfunction

  function automatic stim_t rand_stim(int n);
    stim_t s;
    s.wr_en   = 1'($urandom_range(0, 1));
    s.wr_addr = ra(n);
    s.wr_data = {$urandom, $urandom};
    s.iss_en  = ($urandom_range(0, 2) != 0);
    s.iss_rd  = ra(n);
    s.flush   = ($urandom_range(0, 15) == 0);
    s.rs1     = ($urandom_range(0, 2) == 0) ? s.wr_addr : ra(n);
    s.rs2     = ($urandom_range(0, 3) == 0) ? s.rs1 : ra(n);
    return s;
  endfunction

  // Called just after a rising edge: drive, predict, advance one edge.
  task automatic step(stim_t sa, stim_t sb, string tag);
    exp_t e;
    a_wr_en = sa.wr_en;  a_wr_addr = 5'(sa.wr_addr); a_wr_data = sa.wr_data[31:0];
    a_iss_en = sa.iss_en; a_iss_rd = 5'(sa.iss_rd);  a_flush = sa.flush;
    a_rs1_addr = 5'(sa.rs1); a_rs2_addr = 5'(sa.rs2);
    b_wr_en = sb.wr_en;  b_wr_addr = 4'(sb.wr_addr); b_wr_data = sb.wr_data;
    b_iss_en = sb.iss_en; b_iss_rd = 4'(sb.iss_rd);  b_flush = sb.flush;
    b_rs1_addr = 4'(sb.rs1); b_rs2_addr = 4'(sb.rs2);
    e.tag  = tag;
    e.a_d1 = m_rd(0, sa.rs1, sa); e.a_d2 = m_rd(0, sa.rs2, sa);
    e.a_b1 = m_bz(0, sa.rs1, sa); e.a_b2 = m_bz(0, sa.rs2, sa);
    e.b_d1 = m_rd(1, sb.rs1, sb); e.b_d2 = m_rd(1, sb.rs2, sb);
    e.b_b1 = m_bz(1, sb.rs1, sb); e.b_b2 = m_bz(1, sb.rs2, sb);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_edge(0, sa);
      m_edge(1, sb);
    end
    #1;
  endtask

  // Asserts reset between edges, holds it across one edge with live traffic.
  task automatic reset_pulse(string tag);
    rst = 1'b0;
    m_clear();
    step(rand_stim(32), rand_stim(16), tag);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timed out");
  end

  initial begin : stimulus
    m_clear();
    {a_wr_en, a_iss_en, a_flush, b_wr_en, b_iss_en, b_flush} = '0;
    {a_wr_addr, a_iss_rd, a_rs1_addr, a_rs2_addr, a_wr_data} = '0;
    {b_wr_addr, b_iss_rd, b_rs1_addr, b_rs2_addr, b_wr_data} = '0;
    @(posedge clk);
    #1;
    step(idle(0, 5), idle(0, 5), "reset_hold");
    rst = 1'b1;

    // Write then read, hardwired x0 on A, writable x0 on B.
    step(wr(5, 64'hDEADBEEF, 1, 2), wr(5, 64'hDEADBEEF, 1, 2), "wr_x5");
    step(wr(0, 64'h1234, 5, 3), wr(0, 64'h1234, 5, 3), "wr_x0");
    step(idle(5, 0), idle(5, 0), "rd_x5_x0");

    // Same-cycle forwarding (A) versus next-cycle visibility (B).
    step(wr(7, 64'hA5A5A5A5, 7, 7), wr(7, 64'hA5A5A5A5, 7, 7), "bypass_x7");
    step(idle(7, 7), idle(7, 7), "after_x7");

    // Scoreboard: issue, writeback mask, clear, and issue+writeback on one edge.
    step(iss(9, 9, 9), iss(9, 9, 9), "iss_x9");
    step(wr(9, 64'h99, 9, 9), wr(9, 64'h99, 9, 9), "wb_x9");
    step(idle(9, 9), idle(9, 9), "clr_x9");
    begin
      stim_t s;
      s = iss(9, 9, 9);
      s.wr_en = 1'b1; s.wr_addr = 9; s.wr_data = 64'h77;
      step(s, s, "iss_wb_x9");
    end
    step(idle(9, 9), idle(9, 9), "still_x9");
    step(iss(0, 0, 0), iss(0, 0, 0), "iss_x0");
    step(idle(0, 0), idle(0, 0), "busy_x0");

    // Flush with a simultaneous issue to x6.
    step(iss(3, 3, 4), iss(3, 3, 4), "iss_x3");
    step(iss(4, 3, 4), iss(4, 3, 4), "iss_x4");
    step(iss(31, 3, 4), iss(15, 3, 4), "iss_x31");
    begin
      stim_t s;
      s = iss(6, 3, 4);
      s.flush = 1'b1;
      step(s, s, "flush");
    end
    step(idle(31, 6), idle(15, 6), "post_flush");
    step(idle(3, 4), idle(3, 4), "post_flush2");

    // Wide round trip at the top register of B, and a check that it does not alias.
    step(idle(1, 2), wr(15, 64'hFFFF_0000_FFFF_0000, 15, 7), "wr_x15");
    step(idle(1, 2), idle(15, 7), "rd_x15");
    for (int i = 0; i < 15; i++) step(idle(1, 2), idle(i, 15), "alias_x15");

    // Random traffic with an occasional mid-stream reset.
    for (int c = 0; c < 2000; c++) begin
      if (c % 500 == 250) reset_pulse("reset_mid");
      else step(rand_stim(32), rand_stim(16), "rand");
    end

    step(idle(0, 0), idle(0, 0), "drain");
    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
